instr_register_exec: RTL
========================

// Module: instr_register_exec
// PURPOSE
//   Parametrised next-generation instruction register: stores DEPTH instruction words
//   (opcode, operand_a, operand_b) and, via a one-stage execute pipeline, the computed
//   result and error flag per entry. Random-access write/read by pointer, per-entry valid
//   bits and an occupancy count. Sits between the instruction stimulus and the scoreboard/checker.
// PARAMETERS
//   OP_WIDTH   32               signed operand width
//   DEPTH      32               number of register entries (need not be a power of two)
//   ADDR_WIDTH $clog2(DEPTH)    pointer width (derived; do not override)
//   RES_WIDTH  2*OP_WIDTH       signed result width
// PORTS
//   clk            in   1            single clock; all logic on posedge
//   reset          in   1            synchronous, active-high reset
//   load_en        in   1            write request, sampled on posedge clk
//   write_pointer  in   ADDR_WIDTH   target entry of write
//   opcode         in   opcode_t     ZERO,PASSA,PASSB,ADD,SUB,MULT,DIV,MOD (0..7)
//   operand_a      in   OP_WIDTH     signed
//   operand_b      in   OP_WIDTH     signed
//   read_pointer   in   ADDR_WIDTH   entry to read
//   rd_opcode      out  opcode_t     registered read data
//   rd_op_a        out  OP_WIDTH
//   rd_op_b        out  OP_WIDTH
//   rd_result      out  RES_WIDTH    signed result
//   rd_err         out  1            entry recorded divide/modulo by zero
//   rd_valid       out  1            entry written since reset
//   wr_drop        out  1            1-cycle pulse: write_pointer >= DEPTH, write discarded
//   entry_count    out  ADDR_WIDTH+1 number of valid entries
// BEHAVIOUR
// - Reset (sync, active-high, dominates load_en): all rd_* = 0, rd_valid=0, wr_drop=0,
//   entry_count=0, all valid bits cleared, execute stage emptied (in-flight write discarded).
//   Array data storage is not reset.
// - Write pipeline: edge E0 with load_en=1 captures {ptr,opc,a,b} into stage S1 (s1_valid=1).
//   Edge E1 commits S1: entry <= {opc,a,b,alu_result,alu_err}, valid<=1. Back-to-back
//   loads every cycle supported; S1 is overwritten each edge (s1_valid = load_en).
// - write_pointer >= DEPTH at E0: no capture; wr_drop=1 for the cycle after E0.
// - entry_count: +1 at commit only if target valid bit was 0; overwrite leaves it unchanged.
// - Read: rd_* registered from entry[read_pointer] at every edge (1-cycle latency).
//   read_pointer >= DEPTH or invalid entry -> rd_valid=0 and all rd data 0.
// - ALU (signed): ZERO->0; PASSA/PASSB->sign-extended operand; ADD/SUB sign-extended to
//   RES_WIDTH (no overflow); MULT full-width product; DIV/MOD truncate toward zero,
//   remainder takes sign of operand_a. operand_b==0 for DIV/MOD -> result 0, err=1;
//   err=0 for all other cases.
// - Same-edge commit+read of one address: see CONFIGURATION. An instruction captured
//   into S1 at edge E is never forwarded at E.
// CONFIGURATION
//   `INSTR_REG_BYPASS_EN defined: if s1_valid and S1 pointer == read_pointer at edge E,
//     rd_* take the committing value (rd_valid=1). Load at E0 readable on rd_* after E1.
//   Not defined: read at E returns pre-commit content; load at E0 readable after E2.
// STRUCTURE
// - instr_register_pkg: opcode_t enum (unchanged encodings 0..7), default OP_WIDTH/DEPTH
//   constants. Entry/stage structs depend on parameters and are declared in the module.
// - Sub-module instr_alu: purely combinational, parameters OP_WIDTH/RES_WIDTH,
//   inputs opcode/operand_a/operand_b, outputs result/err. Storage, valid bits,
//   pipeline, bypass and counters stay in instr_register_exec.
// TESTING
// - Reset then read all 0..DEPTH-1 -> rd_valid=0, rd data 0, entry_count=0.
// - Load ptr 3: ADD a=-7 b=5; read 3 two cycles later -> rd_result=-2, rd_err=0,
//   rd_valid=1, entry_count=1; reload ptr 3: MULT a=-3 b=4 -> rd_result=-12, count stays 1.
// - Load DIV a=-7 b=2 -> -3; MOD a=-7 b=2 -> -1; DIV a=5 b=0 -> result 0, rd_err=1.
// - Load ptr 5 at E0, read_pointer=5 at E1 -> with BYPASS rd_valid=1 after E1; without,
//   rd_valid=0 after E1 and 1 after E2.
// - Load at E0 then reset at E1 -> nothing committed, entry_count=0, rd_valid=0 at ptr.
// - DEPTH=20, load_en with write_pointer=25 -> wr_drop pulse, entry_count unchanged.

Source files
------------

// File: rtl/instr_register_exec_pkg.sv
// Shared types and defaults for the instruction register slice.
// Optional feature macro used by instr_register_exec: INSTR_REG_BYPASS_EN.
package instr_register_pkg;

   typedef enum logic [2:0] {
      ZERO  = 3'd0,
      PASSA = 3'd1,
      PASSB = 3'd2,
      ADD   = 3'd3,
      SUB   = 3'd4,
      MULT  = 3'd5,
      DIV   = 3'd6,
      MOD   = 3'd7
   } opcode_t;

   localparam int DEF_OP_WIDTH = 32;
   localparam int DEF_DEPTH    = 32;

   function automatic logic is_div_op(input opcode_t op);
      return (op == DIV) || (op == MOD);
   endfunction

endpackage

// File: rtl/instr_register_exec_alu.sv
// Combinational signed ALU of the execute stage: full-width results, flags
// divide/modulo by zero.
module instr_alu
   import instr_register_pkg::*;
#(
   parameter int OP_WIDTH  = DEF_OP_WIDTH,
   parameter int RES_WIDTH = 2 * OP_WIDTH
) (
   input  opcode_t                      opcode,
   input  logic signed [OP_WIDTH-1:0]   operand_a,
   input  logic signed [OP_WIDTH-1:0]   operand_b,
   output logic signed [RES_WIDTH-1:0]  result,
   output logic                         err
);

   logic signed [RES_WIDTH-1:0] w_a_ext;
   logic signed [RES_WIDTH-1:0] w_b_ext;
   logic signed [RES_WIDTH-1:0] w_b_safe;
   logic                        w_b_zero;

   assign w_a_ext  = {{(RES_WIDTH-OP_WIDTH){operand_a[OP_WIDTH-1]}}, operand_a};
   assign w_b_ext  = {{(RES_WIDTH-OP_WIDTH){operand_b[OP_WIDTH-1]}}, operand_b};
   assign w_b_zero = (operand_b == {OP_WIDTH{1'b0}});
   // Divisor forced to one when zero so the divider never sees a zero operand.
   assign w_b_safe = w_b_zero ? {{(RES_WIDTH-1){1'b0}}, 1'b1} : w_b_ext;

   // Opcode decode; operations run at result width so nothing overflows.
   always_comb begin
      result = {RES_WIDTH{1'b0}};
      err    = 1'b0;
      case (opcode)
         ZERO:  result = {RES_WIDTH{1'b0}};
         PASSA: result = w_a_ext;
         PASSB: result = w_b_ext;
         ADD:   result = w_a_ext + w_b_ext;
         SUB:   result = w_a_ext - w_b_ext;
         MULT:  result = w_a_ext * w_b_ext;
         DIV, MOD: begin
            if (w_b_zero) begin
               result = {RES_WIDTH{1'b0}};
               err    = is_div_op(opcode);
            end else if (opcode == DIV) begin
               result = w_a_ext / w_b_safe;
               err    = 1'b0;
            end else begin
               result = w_a_ext % w_b_safe;
               err    = 1'b0;
            end
         end
         default: begin
            result = {RES_WIDTH{1'b0}};
            err    = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/instr_register_exec.sv
// Instruction register with one-stage execute pipeline, valid bits and occupancy count.
// Define INSTR_REG_BYPASS_EN to forward a committing entry to a same-edge read.
module instr_register_exec
   import instr_register_pkg::*;
#(
   parameter int OP_WIDTH   = DEF_OP_WIDTH,
   parameter int DEPTH      = DEF_DEPTH,
   parameter int ADDR_WIDTH = $clog2(DEPTH),
   parameter int RES_WIDTH  = 2 * OP_WIDTH
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         load_en,
   input  logic [ADDR_WIDTH-1:0]        write_pointer,
   input  opcode_t                      opcode,
   input  logic signed [OP_WIDTH-1:0]   operand_a,
   input  logic signed [OP_WIDTH-1:0]   operand_b,
   input  logic [ADDR_WIDTH-1:0]        read_pointer,
   output opcode_t                      rd_opcode,
   output logic signed [OP_WIDTH-1:0]   rd_op_a,
   output logic signed [OP_WIDTH-1:0]   rd_op_b,
   output logic signed [RES_WIDTH-1:0]  rd_result,
   output logic                         rd_err,
   output logic                         rd_valid,
   output logic                         wr_drop,
   output logic [ADDR_WIDTH:0]          entry_count
);

   typedef struct packed {
      opcode_t                      opc;
      logic signed [OP_WIDTH-1:0]   a;
      logic signed [OP_WIDTH-1:0]   b;
      logic signed [RES_WIDTH-1:0]  res;
      logic                         err;
   } entry_t;

   localparam logic [ADDR_WIDTH:0] DEPTH_C = DEPTH[ADDR_WIDTH:0];

   entry_t                      r_mem [DEPTH];
   logic [DEPTH-1:0]            r_valid;

   logic                        r_s1_valid;
   logic [ADDR_WIDTH-1:0]       r_s1_ptr;
   opcode_t                     r_s1_opc;
   logic signed [OP_WIDTH-1:0]  r_s1_a;
   logic signed [OP_WIDTH-1:0]  r_s1_b;

   logic signed [RES_WIDTH-1:0] w_alu_res;
   logic                        w_alu_err;
   entry_t                      w_commit;
   entry_t                      w_rd_entry;
   logic                        w_wr_in_range;
   logic                        w_rd_in_range;
   logic [ADDR_WIDTH-1:0]       w_rd_idx;
   logic                        w_bypass_hit;

   instr_alu #(
      .OP_WIDTH  (OP_WIDTH),
      .RES_WIDTH (RES_WIDTH)
   ) u_alu (
      .opcode    (r_s1_opc),
      .operand_a (r_s1_a),
      .operand_b (r_s1_b),
      .result    (w_alu_res),
      .err       (w_alu_err)
   );

   assign w_wr_in_range = ({1'b0, write_pointer} < DEPTH_C);
   assign w_rd_in_range = ({1'b0, read_pointer} < DEPTH_C);
   // Clamp keeps the array index legal even for out-of-range pointers.
   assign w_rd_idx      = w_rd_in_range ? read_pointer : {ADDR_WIDTH{1'b0}};
   assign w_rd_entry    = r_mem[w_rd_idx];

`ifdef INSTR_REG_BYPASS_EN
   assign w_bypass_hit = r_s1_valid && (r_s1_ptr == read_pointer);
`else
   assign w_bypass_hit = 1'b0;
`endif

   // Assemble the entry committed from the execute stage.
   always_comb begin
      w_commit     = '0;
      w_commit.opc = r_s1_opc;
      w_commit.a   = r_s1_a;
      w_commit.b   = r_s1_b;
      w_commit.res = w_alu_res;
      w_commit.err = w_alu_err;
   end

   // Entry storage: never reset, written only by a surviving commit.
   always_ff @(posedge clk) begin
      if (!reset && r_s1_valid) begin
         r_mem[r_s1_ptr] <= w_commit;
      end
   end

   // Pipeline stage, valid bits, occupancy, drop pulse and registered read port.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_s1_valid  <= 1'b0;
         r_s1_ptr    <= {ADDR_WIDTH{1'b0}};
         r_s1_opc    <= ZERO;
         r_s1_a      <= {OP_WIDTH{1'b0}};
         r_s1_b      <= {OP_WIDTH{1'b0}};
         r_valid     <= {DEPTH{1'b0}};
         entry_count <= {(ADDR_WIDTH+1){1'b0}};
         wr_drop     <= 1'b0;
         rd_opcode   <= ZERO;
         rd_op_a     <= {OP_WIDTH{1'b0}};
         rd_op_b     <= {OP_WIDTH{1'b0}};
         rd_result   <= {RES_WIDTH{1'b0}};
         rd_err      <= 1'b0;
         rd_valid    <= 1'b0;
      end else begin
         r_s1_valid <= load_en && w_wr_in_range;
         r_s1_ptr   <= write_pointer;
         r_s1_opc   <= opcode;
         r_s1_a     <= operand_a;
         r_s1_b     <= operand_b;
         wr_drop    <= load_en && !w_wr_in_range;

         if (r_s1_valid) begin
            r_valid[r_s1_ptr] <= 1'b1;
            if (!r_valid[r_s1_ptr]) begin
               entry_count <= entry_count + {{ADDR_WIDTH{1'b0}}, 1'b1};
            end else begin
               entry_count <= entry_count;
            end
         end else begin
            entry_count <= entry_count;
         end

         if (w_bypass_hit) begin
            rd_opcode <= w_commit.opc;
            rd_op_a   <= w_commit.a;
            rd_op_b   <= w_commit.b;
            rd_result <= w_commit.res;
            rd_err    <= w_commit.err;
            rd_valid  <= 1'b1;
         end else if (w_rd_in_range && r_valid[w_rd_idx]) begin
            rd_opcode <= w_rd_entry.opc;
            rd_op_a   <= w_rd_entry.a;
            rd_op_b   <= w_rd_entry.b;
            rd_result <= w_rd_entry.res;
            rd_err    <= w_rd_entry.err;
            rd_valid  <= 1'b1;
         end else begin
            rd_opcode <= ZERO;
            rd_op_a   <= {OP_WIDTH{1'b0}};
            rd_op_b   <= {OP_WIDTH{1'b0}};
            rd_result <= {RES_WIDTH{1'b0}};
            rd_err    <= 1'b0;
            rd_valid  <= 1'b0;
         end
      end
   end

endmodule
